varsplit: RTL and testbench
===========================

# varsplit

Token redistribution controller: a conserved pool of `TOTAL` units starts in a hub register and is moved one unit per cycle between the hub and four spoke registers. Moves are requested through a valid/ready command port. This block is the counterpart to the merge-style sum benchmark: it distributes out of the hub rather than accumulating into it. It is a model-checking sample with embedded conservation assertions, and it also serves as a driver that produces reachable, bounded states for downstream benchmarks.

## Interface
- `W`, 8, data width of the hub, spoke, amount and moved registers.
- `TOTAL`, 5, units in the pool. Required: 1 ≤ `TOTAL` ≤ 2^W−1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: command present.
- `req_ready` output 1: block can accept a command.
- `req_dir` input 1: 0 = hub→spoke, 1 = spoke→hub.
- `req_sel` input 2: spoke index, 0..3.
- `req_amt` input W: requested unit count.
- `busy` output 1: a transfer is in progress.
- `done` output 1: one-cycle completion pulse.
- `moved` output W: units moved by the last or current command.
- `hub` output W: hub register.
- `spoke0`..`spoke3` output W each: spoke registers.

## Operation
- **Reset** (`rst_n`=0, takes effect immediately):
  - `hub`=`TOTAL`, all spokes=0, `moved`=0, state=IDLE.
  - `done`=0, `busy`=0, `req_ready`=1.
- **States:** IDLE, MOVE, DONE.
- **Outputs by state:**
  - `req_ready`=1 only in IDLE.
  - `busy`=1 only in MOVE.
  - `done`=1 only in DONE.
- **Accept:** rising edge with state IDLE and `req_valid`=1.
  - Latch `dir` and `sel`.
  - Source = hub if `dir`=0, else the selected spoke.
  - Compute `rem` = min(`req_amt`, source value at the accept edge).
  - Clear `moved` to 0.
  - Next state: MOVE if `rem`>0, else DONE.
- **Ignored inputs:** `req_*` is ignored outside IDLE and when `req_valid`=0. The block never stalls indefinitely.
- **MOVE** (each edge):
  - Source −1, destination +1.
  - `rem` −1, `moved` +1.
  - When `rem` goes 1→0, the next state is DONE.
- **DONE:** one cycle, then IDLE.
- **`moved`:** holds its value from completion until the next accept.
- **Arithmetic:** all updates are mod 2^W, but they never wrap. This follows from the clamp plus conservation. No saturation logic is needed.
- **Same-spoke commands:** a spoke selected for both source and destination is impossible, because one end is always the hub.
- **Embedded assertions** (checked every cycle while `rst_n`=1):
  - `hub`+`spoke0`+…+`spoke3` == `TOTAL`. The sum is computed in W+3 bits.
  - Each of the five registers ≤ `TOTAL`.
  - `moved` ≤ the latched `req_amt`.
  - `busy`, `done` and `req_ready` are mutually exclusive, and exactly one is high.
- **Reset mid-transfer:** the transfer is abandoned and all registers return to reset values. Conservation therefore holds across reset.

## Timing
- **Accept at edge E0 with clamped count k>0:**
  - Units move at edges E1..Ek.
  - `done`=1 during the cycle after Ek.
  - `req_ready`=1 again after edge Ek+1.
  - Command-to-next-accept spacing is k+2 edges.
- **k=0** (`req_amt`=0 or empty source): `done` during the cycle after E0, `req_ready` after E1, no register changes.
- **Combinational path:** none from `req_*` to any output. All outputs are registered or decoded from state.
- **Throughput:** one unit per cycle. A back-to-back `req_valid` held high is accepted on the first IDLE edge.

## Test plan
- **Reset values:** reset, then release → `hub`=5, spokes 0, `req_ready`=1, `busy`=0, `done`=0, `moved`=0.
- **Hub→spoke:** dir=0, sel=2, amt=3 → `spoke2` 1,2,3 on three successive edges, `hub` 4,3,2, `done` pulse one cycle later, `moved`=3, sum stays 5.
- **Clamp:** with `spoke2`=3, dir=1, sel=2, amt=200 → exactly 3 units move, `hub`=5, `spoke2`=0, `moved`=3.
- **Empty source:** dir=1, sel=0 with `spoke0`=0, amt=4 → no MOVE cycles, `done` the cycle after accept, `moved`=0, registers unchanged.
- **Ignored commands:** toggle `req_valid` and `req_*` while `busy`=1 → no effect. The next accept occurs only in IDLE, k+2 edges after the previous accept.
- **Async reset mid-transfer:** hub→spoke1 with amt=5; assert `rst_n` low after 2 units → outputs return to reset values immediately. The conservation assertion never fires.

Source files
------------

// File: rtl/varsplit_if.sv
// -----------------------------------------------------------------------------
// varsplit_if -- command port of the varsplit token redistribution controller.
//
// Signals:
//   req_valid  command present (master -> slave)
//   req_ready  controller can accept a command (slave -> master)
//   req_dir    0 = hub->spoke, 1 = spoke->hub
//   req_sel    spoke index 0..3
//   req_amt    requested unit count, W bits
// -----------------------------------------------------------------------------
interface varsplit_if #(
   parameter int W = 8
);
   logic         req_valid;
   logic         req_ready;
   logic         req_dir;
   logic [1:0]   req_sel;
   logic [W-1:0] req_amt;

   modport master (
      output req_valid,
      output req_dir,
      output req_sel,
      output req_amt,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_dir,
      input  req_sel,
      input  req_amt,
      output req_ready
   );
endinterface

// File: rtl/varsplit.sv
// -----------------------------------------------------------------------------
// varsplit -- token redistribution controller.
//
// A pool of TOTAL units starts in the hub and is moved one unit per clock
// between the hub and one of four spokes. A command names a direction, a spoke
// and an amount; the amount is clamped to what the source actually holds, so
// no register ever underflows or exceeds TOTAL.
//
// Ports:
//   clk              clock, rising edge
//   rst_n            asynchronous active-low reset
//   req              command port (varsplit_if.slave)
//   busy             high while units are moving (MOVE)
//   done             one-cycle completion pulse (DONE)
//   moved            units moved by the current / last command
//   hub              hub register
//   spoke0..spoke3   spoke registers
// -----------------------------------------------------------------------------
module varsplit #(
   parameter int W     = 8,
   parameter int TOTAL = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   varsplit_if.slave    req,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] moved,
   output logic [W-1:0] hub,
   output logic [W-1:0] spoke0,
   output logic [W-1:0] spoke1,
   output logic [W-1:0] spoke2,
   output logic [W-1:0] spoke3
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MOVE = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [W-1:0] TOTAL_W = W'(TOTAL);
   localparam logic [W-1:0] ONE_W   = {{(W-1){1'b0}}, 1'b1};

   state_t       state;
   state_t       state_nxt;

   logic [W-1:0] hub_q;
   logic [W-1:0] spoke_q [4];
   logic [W-1:0] moved_q;
   logic [W-1:0] rem_q;
   logic [W-1:0] amt_q;
   logic         dir_q;
   logic [1:0]   sel_q;

   logic         accept;
   logic [W-1:0] src_val;
   logic [W-1:0] rem_acc;

   // Clamp the request to what the source holds; this clamp is what keeps
   // every later decrement from wrapping.
   function automatic logic [W-1:0] clamp_amt(input logic [W-1:0] amt,
                                              input logic [W-1:0] avail);
      return (amt < avail) ? amt : avail;
   endfunction

   assign accept  = (state == S_IDLE) && req.req_valid;
   assign src_val = req.req_dir ? spoke_q[req.req_sel] : hub_q;
   assign rem_acc = clamp_amt(req.req_amt, src_val);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (req.req_valid) begin
               state_nxt = (rem_acc != '0) ? S_MOVE : S_DONE;
            end
         end
         S_MOVE: begin
            if (rem_q == ONE_W) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Pool registers and progress counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hub_q   <= TOTAL_W;
         moved_q <= '0;
         rem_q   <= '0;
         for (int i = 0; i < 4; i++) begin
            spoke_q[i] <= '0;
         end
      end else if (accept) begin
         rem_q   <= rem_acc;
         moved_q <= '0;
      end else if (state == S_MOVE) begin
         rem_q   <= rem_q - ONE_W;
         moved_q <= moved_q + ONE_W;
         if (dir_q) begin
            spoke_q[sel_q] <= spoke_q[sel_q] - ONE_W;
            hub_q          <= hub_q + ONE_W;
         end else begin
            hub_q          <= hub_q - ONE_W;
            spoke_q[sel_q] <= spoke_q[sel_q] + ONE_W;
         end
      end
   end

   // Command latch; only meaningful after an accept, so no reset needed
   always_ff @(posedge clk) begin
      if (accept) begin
         dir_q <= req.req_dir;
         sel_q <= req.req_sel;
         amt_q <= req.req_amt;
      end
   end

   assign req.req_ready = (state == S_IDLE);
   assign busy          = (state == S_MOVE);
   assign done          = (state == S_DONE);
   assign moved         = moved_q;
   assign hub           = hub_q;
   assign spoke0        = spoke_q[0];
   assign spoke1        = spoke_q[1];
   assign spoke2        = spoke_q[2];
   assign spoke3        = spoke_q[3];

   // Conservation and bound properties; the pool sum is widened by three bits
   // so that five W-bit terms cannot overflow.
   logic [W+2:0] pool_sum;
   assign pool_sum = (W+3)'(hub_q) + (W+3)'(spoke_q[0]) + (W+3)'(spoke_q[1])
                   + (W+3)'(spoke_q[2]) + (W+3)'(spoke_q[3]);

   a_conserve: assert property (@(posedge clk) disable iff (!rst_n)
      pool_sum == (W+3)'(TOTAL));

   a_bounds: assert property (@(posedge clk) disable iff (!rst_n)
      (hub_q <= TOTAL_W) && (spoke_q[0] <= TOTAL_W) && (spoke_q[1] <= TOTAL_W)
      && (spoke_q[2] <= TOTAL_W) && (spoke_q[3] <= TOTAL_W));

   a_moved: assert property (@(posedge clk) disable iff (!rst_n)
      (state == S_IDLE) || (moved_q <= amt_q));

   a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot({busy, done, req.req_ready}));

endmodule

// File: tb/tb_varsplit.sv
// -----------------------------------------------------------------------------
// tb_varsplit -- self-checking bench for varsplit with a transaction-level
// model of the pool (hub plus four spokes) and the per-command timeline.
// -----------------------------------------------------------------------------
module tb_varsplit;
   localparam int W     = 8;
   localparam int TOTAL = 5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         busy;
   logic         done;
   logic [W-1:0] moved;
   logic [W-1:0] hub;
   logic [W-1:0] spoke0;
   logic [W-1:0] spoke1;
   logic [W-1:0] spoke2;
   logic [W-1:0] spoke3;

   varsplit_if #(.W(W)) bus ();

   varsplit #(.W(W), .TOTAL(TOTAL)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (bus.slave),
      .busy   (busy),
      .done   (done),
      .moved  (moved),
      .hub    (hub),
      .spoke0 (spoke0),
      .spoke1 (spoke1),
      .spoke2 (spoke2),
      .spoke3 (spoke3)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference pool contents between commands
   int m_hub;
   int m_sp [4];
   // Expected pool contents at the current sample point
   int e_hub;
   int e_sp [4];

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int dut_spoke(input int i);
      case (i)
         0:       return int'(spoke0);
         1:       return int'(spoke1);
         2:       return int'(spoke2);
         default: return int'(spoke3);
      endcase
   endfunction

   task automatic check_state(input string tag, input int e_moved,
                              input int e_rdy, input int e_busy, input int e_done);
      int sum;
      check({tag, ".hub"}, int'(hub), e_hub);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s.spoke%0d", tag, i), dut_spoke(i), e_sp[i]);
      end
      sum = int'(hub) + int'(spoke0) + int'(spoke1) + int'(spoke2) + int'(spoke3);
      check({tag, ".sum"},   sum,              TOTAL);
      check({tag, ".moved"}, int'(moved),      e_moved);
      check({tag, ".ready"}, int'(bus.req_ready), e_rdy);
      check({tag, ".busy"},  int'(busy),       e_busy);
      check({tag, ".done"},  int'(done),       e_done);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_hub = TOTAL;
      for (int i = 0; i < 4; i++) m_sp[i] = 0;
      e_hub = m_hub;
      for (int i = 0; i < 4; i++) e_sp[i] = m_sp[i];
   endtask

   // Expected pool after i units of a (dir, sel) command have moved
   task automatic expect_after(input int dir, input int sel, input int i);
      e_hub = m_hub;
      for (int j = 0; j < 4; j++) e_sp[j] = m_sp[j];
      if (dir == 0) begin
         e_hub     -= i;
         e_sp[sel] += i;
      end else begin
         e_sp[sel] -= i;
         e_hub     += i;
      end
   endtask

   task automatic apply_noise(input bit noise);
      if (noise) begin
         bus.req_valid = 1'($urandom_range(0, 1));
         bus.req_dir   = 1'($urandom_range(0, 1));
         bus.req_sel   = 2'($urandom_range(0, 3));
         bus.req_amt   = W'($urandom_range(0, 255));
      end else begin
         bus.req_valid = 1'b0;
      end
   endtask

   // Issue one command from IDLE and follow it edge by edge until IDLE again.
   task automatic run_cmd(input string tag, input int dir, input int sel,
                          input int amt, input bit noise);
      int src;
      int k;
      src = (dir != 0) ? m_sp[sel] : m_hub;
      k   = (amt < src) ? amt : src;
      bus.req_valid = 1'b1;
      bus.req_dir   = 1'(dir);
      bus.req_sel   = 2'(sel);
      bus.req_amt   = W'(amt);
      tick();                              // accept edge E0
      apply_noise(noise);
      for (int i = 0; i <= k; i++) begin
         if (i > 0) begin
            tick();                        // edge Ei
            apply_noise(noise);
         end
         expect_after(dir, sel, i);
         check_state($sformatf("%s.e%0d", tag, i), i, 0,
                     (i < k) ? 1 : 0, (i == k) ? 1 : 0);
      end
      tick();                              // edge Ek+1, back to IDLE
      bus.req_valid = 1'b0;
      expect_after(dir, sel, k);
      check_state({tag, ".idle"}, k, 1, 0, 0);
      m_hub = e_hub;
      for (int j = 0; j < 4; j++) m_sp[j] = e_sp[j];
   endtask

   task automatic do_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_state({tag, ".async"}, 0, 1, 0, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_state({tag, ".rel"}, 0, 1, 0, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_dir   = 1'b0;
      bus.req_sel   = 2'd0;
      bus.req_amt   = '0;
      model_reset();

      // Reset values
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_state("reset", 0, 1, 0, 0);

      // Directed scenarios
      run_cmd("h2s",   0, 2, 3,   1'b0);
      run_cmd("clamp", 1, 2, 200, 1'b0);
      run_cmd("empty", 1, 0, 4,   1'b0);
      run_cmd("noise", 0, 3, 4,   1'b1);
      run_cmd("back",  1, 3, 2,   1'b1);
      run_cmd("zero",  0, 1, 0,   1'b0);

      // Randomized commands, back to back
      for (int n = 0; n < 40; n++) begin
         int amt;
         amt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                           : int'($urandom_range(0, 6));
         run_cmd($sformatf("rnd%0d", n), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), amt, 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset in the middle of a transfer
      do_reset("pre");
      bus.req_valid = 1'b1;
      bus.req_dir   = 1'b0;
      bus.req_sel   = 2'd1;
      bus.req_amt   = W'(5);
      tick();
      bus.req_valid = 1'b0;
      tick();
      tick();
      expect_after(0, 1, 2);
      check_state("mid", 2, 0, 1, 0);
      do_reset("midrst");

      // Pool still usable after the abandoned transfer
      run_cmd("post", 0, 1, 5, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
